lane_traffic: RTL

- Parametrised successor to the single-car mover: one screen lane holding NUM_VEH equally spaced vehicles that share direction, step and speed divider.
- Vehicles wrap continuously through an off-screen region.
- MODE selects hazard lane (cars: overlap kills the frog) or platform lane (logs: overlap carries the frog; missing every platform kills it).
- One instance per lane under the game top level. Clocked by frame_clk (one tick per video frame).

---
 rtl/lane_traffic.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lane_traffic.sv
// One lane of equally spaced vehicles wrapping through an off-screen track,
// with a registered frog hit test (hazard cars or rideable platforms).
module lane_traffic #(
  parameter int NUM_VEH   = 3,
  parameter int VEH_W     = 80,
  parameter int VEH_H     = 40,
  parameter int STEP      = 5,
  parameter int SCREEN_W  = 640,
  parameter int SPACING   = 240,
  parameter int TOL       = 10,
  parameter int FROG_SIDE = 40,
  parameter int MODE      = 0
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   Restart,
  input  logic [10:0]            Start_X,
  input  logic [10:0]            Lane_Y,
  input  logic                   Direction,
  input  logic [5:0]             Speed,
  input  logic [10:0]            Frog_X,
  input  logic [10:0]            Frog_Y,
  input  logic                   win,
  input  logic                   lose,
  output logic [NUM_VEH*11-1:0]  Veh_X,
  output logic [10:0]            Veh_Y,
  output logic [10:0]            Veh_W,
  output logic [10:0]            Veh_H,
  output logic                   Collision,
  output logic                   On_Platform,
  output logic [1:0]             Carry_Dx
);

  localparam int TRACK = SCREEN_W + VEH_W;
  localparam logic [11:0] L_T    = 12'(TRACK);
  localparam logic [11:0] L_STEP = 12'(STEP);
  localparam logic [11:0] L_VW   = 12'(VEH_W);
  localparam logic [11:0] L_VH   = 12'(VEH_H);
  localparam logic [11:0] L_TOL  = 12'(TOL);
  localparam logic [11:0] L_FS   = 12'(FROG_SIDE);

  typedef enum logic {ST_WAIT, ST_MOVE} state_t;

  state_t       r_state;
  logic [5:0]   r_count;
  logic [11:0]  r_pos [NUM_VEH];

  logic [11:0]        w_start [NUM_VEH];
  logic [11:0]        w_next  [NUM_VEH];
  logic [NUM_VEH-1:0] w_hit;
  logic [11:0]        w_fl;
  logic [11:0]        w_fr;
  logic               w_row;
  logic               w_anyHit;
  logic               w_frozen;

  // Frog hitbox expressed in track coordinates (screen X + VEH_W), shrunk by TOL.
  assign w_fl     = {1'b0, Frog_X} + L_VW + L_TOL;
  assign w_fr     = {1'b0, Frog_X} + L_VW + L_FS - L_TOL;
  assign w_row    = (({1'b0, Frog_Y} + L_TOL) <= ({1'b0, Lane_Y} + L_VH)) &&
                    (({1'b0, Frog_Y} + L_FS - L_TOL) >= {1'b0, Lane_Y});
  assign w_anyHit = |w_hit;
  assign w_frozen = win | lose;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VEH; gi++) begin : g_veh
      logic [31:0] w_sum;
      assign w_sum       = 32'(Start_X) + 32'(gi * SPACING);
      assign w_start[gi] = 12'(w_sum % 32'(TRACK));

      // Wrap explicitly rather than with modulo so every vehicle stays in [0, T-1].
      assign w_next[gi] = Direction
        ? (((r_pos[gi] + L_STEP) >= L_T) ? (r_pos[gi] + L_STEP - L_T) : (r_pos[gi] + L_STEP))
        : ((r_pos[gi] < L_STEP) ? (r_pos[gi] + L_T - L_STEP) : (r_pos[gi] - L_STEP));

      assign w_hit[gi] = (w_fl <= (r_pos[gi] + L_VW)) && (w_fr >= r_pos[gi]) && w_row;

      assign Veh_X[gi*11 +: 11] = 11'(r_pos[gi] - L_VW);
    end
  endgenerate

  assign Veh_Y = Lane_Y;
  assign Veh_W = 11'(VEH_W);
  assign Veh_H = 11'(VEH_H);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_VEH; i++) r_pos[i] <= w_start[i];
      r_state     <= ST_WAIT;
      r_count     <= 6'd0;
      Collision   <= 1'b0;
      On_Platform <= 1'b0;
      Carry_Dx    <= 2'b00;
    end else if (Restart) begin
      for (int i = 0; i < NUM_VEH; i++) r_pos[i] <= w_start[i];
      r_state     <= ST_WAIT;
      r_count     <= 6'd0;
      Collision   <= 1'b0;
      On_Platform <= 1'b0;
      Carry_Dx    <= 2'b00;
    end else begin
      if (MODE == 0) begin
        Collision   <= w_anyHit && !w_frozen;
        On_Platform <= 1'b0;
        Carry_Dx    <= 2'b00;
      end else begin
        Collision   <= w_row && !w_anyHit && !w_frozen;
        On_Platform <= w_anyHit;
        Carry_Dx    <= ((r_state == ST_MOVE) && w_anyHit && !w_frozen)
                       ? (Direction ? 2'b01 : 2'b10) : 2'b00;
      end

      // Count saturates at Speed so a lowered Speed or a freeze never overshoots.
      case (r_state)
        ST_WAIT: begin
          if ((r_count == Speed) && !w_frozen) r_state <= ST_MOVE;
          else r_count <= (r_count >= Speed) ? Speed : (r_count + 6'd1);
        end
        ST_MOVE: begin
          for (int i = 0; i < NUM_VEH; i++) r_pos[i] <= w_next[i];
          r_count <= 6'd0;
          r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

endmodule
